multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the 8-bit-instruction, 4-bit-opcode datapath through FETCH, DECODE, EXEC, MEM and WB.
- Drives the PC, IR, ALU, register file and the shared instruction/data memory port with a req/ack handshake.
- Sits between the memory interface and the datapath; datapath muxes and the ALU are instantiated elsewhere.

---
 rtl/multicycle_sequencer_pkg.sv | 66 ++++++
 rtl/multicycle_sequencer_op_decode.sv | 63 ++++++
 rtl/multicycle_sequencer.sv | 152 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcodes,
// ALU codes, PC source and register-file write-data selects.
package ctrl_pkg;

    // FSM state encoding; codes 6 and 7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    // Opcodes, taken from inst[7:4].
    localparam logic [3:0] OP_MOVE = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_LI   = 4'hF;

    // ALU operation codes.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_NOT  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_PASS = 4'b1000;

    // PC source select.
    localparam logic [1:0] PC_SEL_INC    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    // Register-file write-data select.
    localparam logic [1:0] DMUX_ALU = 2'b00;
    localparam logic [1:0] DMUX_MEM = 2'b01;
    localparam logic [1:0] DMUX_PC1 = 2'b10;
    localparam logic [1:0] DMUX_IMM = 2'b11;

    // Instruction class: decides the path taken after EXEC.
    typedef enum logic [2:0] {
        CLS_WB    = 3'd0,   // register ops, addi, li: EXEC -> WB
        CLS_LOAD  = 3'd1,   // lw: EXEC -> MEM -> WB
        CLS_STORE = 3'd2,   // sw: EXEC -> MEM -> boundary
        CLS_JUMP  = 3'd3,   // j
        CLS_JAL   = 3'd4,   // jal
        CLS_BEQ   = 3'd5,
        CLS_BNE   = 3'd6
    } inst_class_t;

endpackage

// File: rtl/multicycle_sequencer_op_decode.sv
// Combinational opcode decode: ALU code, B-operand select, write-data
// select and instruction class for the sequencer FSM.
module op_decode
    import ctrl_pkg::*;
(
    input  logic [3:0]  i_op,
    output logic [3:0]  o_alu_control,
    output logic        o_alu_mux_select,
    output logic [1:0]  o_dmux,
    output inst_class_t o_cls
);

    // Map opcode to ALU setup, write-data source and control-flow class.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        o_alu_control    = ALU_ADD;
        o_alu_mux_select = 1'b0;
        o_dmux           = DMUX_ALU;
        o_cls            = CLS_WB;
        case (i_op)
            OP_MOVE: o_alu_control = ALU_PASS;
            OP_ADD:  o_alu_control = ALU_ADD;
            OP_AND:  o_alu_control = ALU_AND;
            OP_NOT:  o_alu_control = ALU_NOT;
            OP_NOR:  o_alu_control = ALU_NOR;
            OP_SLT:  o_alu_control = ALU_SLT;
            OP_SLL: begin
                o_alu_control    = ALU_SLL;
                o_alu_mux_select = 1'b1;
            end
            OP_SRL: begin
                o_alu_control    = ALU_SRL;
                o_alu_mux_select = 1'b1;
            end
            OP_J:    o_cls = CLS_JUMP;
            OP_JAL: begin
                o_cls  = CLS_JAL;
                o_dmux = DMUX_PC1;
            end
            OP_LW: begin
                o_alu_mux_select = 1'b1;
                o_dmux           = DMUX_MEM;
                o_cls            = CLS_LOAD;
            end
            OP_SW: begin
                o_alu_mux_select = 1'b1;
                o_cls            = CLS_STORE;
            end
            OP_BEQ: begin
                o_alu_control = ALU_SUB;
                o_cls         = CLS_BEQ;
            end
            OP_BNE: begin
                o_alu_control = ALU_SUB;
                o_cls         = CLS_BNE;
            end
            OP_ADDI: o_alu_mux_select = 1'b1;
            OP_LI:   o_dmux = DMUX_IMM;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB for an 8-bit
// instruction datapath sharing one instruction/data memory port.
module multicycle_sequencer
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       halt_req,
    input  logic [7:0] inst,
    input  logic       mem_ack,
    input  logic       alu_zero,
    output logic       mem_req,
    output logic       inst_mem_sel,
    output logic       data_mem_wren,
    output logic       ir_wren,
    output logic       pc_wren,
    output logic [1:0] pc_control,
    output logic [3:0] alu_control,
    output logic       alu_mux_select,
    output logic       reg_file_wren,
    output logic [1:0] reg_file_dmux_select,
    output logic       reg_file_rmux_select,
    output logic       busy,
    output logic [2:0] state
);

    state_t      r_state;
    state_t      w_next;
    state_t      w_boundary;
    logic [3:0]  r_op_q;
    logic [3:0]  w_alu_control;
    logic        w_alu_mux_select;
    logic [1:0]  w_dmux;
    inst_class_t w_cls;
    logic        w_unused;

    // Operand fields of the instruction are consumed by the datapath, not here.
    assign w_unused = ^inst[3:0];

    op_decode u_op_decode (
        .i_op             (r_op_q),
        .o_alu_control    (w_alu_control),
        .o_alu_mux_select (w_alu_mux_select),
        .o_dmux           (w_dmux),
        .o_cls            (w_cls)
    );

    // State register; async reset forces IDLE so every output drops at once.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Opcode register, captured together with the IR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_op_q <= 4'b0000;
        else if (ir_wren) r_op_q <= inst[7:4];
    end

    assign w_boundary = halt_req ? ST_IDLE : ST_FETCH;
    assign busy       = (r_state != ST_IDLE);
    assign state      = r_state;

    // Next-state and output decode from state and op_q; mem_ack/alu_zero act as Mealy inputs.
    always_comb begin
        w_next               = r_state;
        mem_req              = 1'b0;
        inst_mem_sel         = 1'b0;
        data_mem_wren        = 1'b0;
        ir_wren              = 1'b0;
        pc_wren              = 1'b0;
        pc_control           = PC_SEL_INC;
        alu_control          = ALU_ADD;
        alu_mux_select       = 1'b0;
        reg_file_wren        = 1'b0;
        reg_file_dmux_select = DMUX_ALU;
        reg_file_rmux_select = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req      = 1'b1;
                inst_mem_sel = 1'b1;
                if (mem_ack) begin
                    ir_wren = 1'b1;
                    w_next  = ST_DECODE;
                end
            end
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC: begin
                alu_control    = w_alu_control;
                alu_mux_select = w_alu_mux_select;
                case (w_cls)
                    CLS_WB:    w_next = ST_WB;
                    CLS_LOAD,
                    CLS_STORE: w_next = ST_MEM;
                    CLS_JUMP: begin
                        pc_wren    = 1'b1;
                        pc_control = PC_SEL_JUMP;
                        w_next     = w_boundary;
                    end
                    CLS_JAL: begin
                        pc_wren              = 1'b1;
                        pc_control           = PC_SEL_JUMP;
                        reg_file_wren        = 1'b1;
                        reg_file_dmux_select = w_dmux;
                        reg_file_rmux_select = 1'b1;
                        w_next               = w_boundary;
                    end
                    CLS_BEQ: begin
                        pc_wren    = 1'b1;
                        pc_control = alu_zero ? PC_SEL_BRANCH : PC_SEL_INC;
                        w_next     = w_boundary;
                    end
                    CLS_BNE: begin
                        pc_wren    = 1'b1;
                        pc_control = alu_zero ? PC_SEL_INC : PC_SEL_BRANCH;
                        w_next     = w_boundary;
                    end
                    default: w_next = ST_IDLE;
                endcase
            end
            ST_MEM: begin
                mem_req        = 1'b1;
                alu_control    = w_alu_control;
                alu_mux_select = w_alu_mux_select;
                data_mem_wren  = (w_cls == CLS_STORE);
                if (mem_ack) begin
                    if (w_cls == CLS_STORE) begin
                        pc_wren = 1'b1;
                        w_next  = w_boundary;
                    end else begin
                        w_next  = ST_WB;
                    end
                end
            end
            ST_WB: begin
                alu_control          = w_alu_control;
                alu_mux_select       = w_alu_mux_select;
                reg_file_wren        = 1'b1;
                pc_wren              = 1'b1;
                reg_file_dmux_select = w_dmux;
                w_next               = w_boundary;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed-vector bench for multicycle_sequencer with hand-computed expectations.
module tb_multicycle_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       halt_req;
    logic [7:0] inst;
    logic       mem_ack;
    logic       alu_zero;
    logic       mem_req;
    logic       inst_mem_sel;
    logic       data_mem_wren;
    logic       ir_wren;
    logic       pc_wren;
    logic [1:0] pc_control;
    logic [3:0] alu_control;
    logic       alu_mux_select;
    logic       reg_file_wren;
    logic [1:0] reg_file_dmux_select;
    logic       reg_file_rmux_select;
    logic       busy;
    logic [2:0] state;

    int n_vec;
    int n_err;

    multicycle_sequencer dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .start                (start),
        .halt_req             (halt_req),
        .inst                 (inst),
        .mem_ack              (mem_ack),
        .alu_zero             (alu_zero),
        .mem_req              (mem_req),
        .inst_mem_sel         (inst_mem_sel),
        .data_mem_wren        (data_mem_wren),
        .ir_wren              (ir_wren),
        .pc_wren              (pc_wren),
        .pc_control           (pc_control),
        .alu_control          (alu_control),
        .alu_mux_select       (alu_mux_select),
        .reg_file_wren        (reg_file_wren),
        .reg_file_dmux_select (reg_file_dmux_select),
        .reg_file_rmux_select (reg_file_rmux_select),
        .busy                 (busy),
        .state                (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, let outputs settle.
    task automatic cyc(input logic ack, input logic [7:0] ins, input logic az,
                       input logic hr, input logic st);
        @(negedge clk);
        mem_ack  = ack;
        inst     = ins;
        alu_zero = az;
        halt_req = hr;
        start    = st;
        #1;
    endtask

    // All strobes and selects packed into one vector.
    function automatic logic [15:0] strobes();
        return {mem_req, inst_mem_sel, data_mem_wren, ir_wren, pc_wren, pc_control,
                alu_control, alu_mux_select, reg_file_wren, reg_file_dmux_select,
                reg_file_rmux_select};
    endfunction

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        halt_req = 1'b0;
        inst     = 8'h00;
        mem_ack  = 1'b0;
        alu_zero = 1'b0;
        #1;
        check("reset_state", {13'd0, state}, 16'd0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_strobes", strobes(), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle with start low: nothing moves for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check("idle_state", {13'd0, state}, 16'd0);
            check("idle_busy", {15'd0, busy}, 16'd0);
            check("idle_strobes", strobes(), 16'h0000);
        end

        // add 0x13, zero-wait fetch: FETCH, DECODE, EXEC, WB, FETCH.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
        check("add_fetch_state", {13'd0, state}, 16'd1);
        check("add_fetch_req", {14'd0, mem_req, inst_mem_sel}, 16'b11);
        check("add_fetch_irw", {15'd0, ir_wren}, 16'd1);
        check("add_fetch_busy", {15'd0, busy}, 16'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("add_decode_state", {13'd0, state}, 16'd2);
        check("add_decode_strb", {11'd0, mem_req, ir_wren, pc_wren, reg_file_wren, data_mem_wren}, 16'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("add_exec_state", {13'd0, state}, 16'd3);
        check("add_exec_alu", {11'd0, alu_control, alu_mux_select}, {11'd0, 4'b0000, 1'b0});
        check("add_exec_rfw", {15'd0, reg_file_wren}, 16'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("add_wb_state", {13'd0, state}, 16'd5);
        check("add_wb_ctl", {10'd0, reg_file_wren, reg_file_dmux_select, pc_wren, pc_control},
              {10'd0, 1'b1, 2'b00, 1'b1, 2'b00});

        // lw 0xA0, zero-wait fetch, ack delayed two cycles in MEM: 7 cycles.
        cyc(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
        check("lw_fetch_state", {13'd0, state}, 16'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("lw_decode_state", {13'd0, state}, 16'd2);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("lw_exec_state", {13'd0, state}, 16'd3);
        check("lw_exec_alu", {11'd0, alu_control, alu_mux_select}, {11'd0, 4'b0000, 1'b1});
        for (int i = 0; i < 3; i++) begin
            cyc((i == 2) ? 1'b1 : 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check("lw_mem_state", {13'd0, state}, 16'd4);
            check("lw_mem_port", {13'd0, mem_req, inst_mem_sel, data_mem_wren}, 16'b100);
            check("lw_mem_alu", {11'd0, alu_control, alu_mux_select}, {11'd0, 4'b0000, 1'b1});
            check("lw_mem_pcw", {15'd0, pc_wren}, 16'd0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("lw_wb_state", {13'd0, state}, 16'd5);
        check("lw_wb_ctl", {12'd0, reg_file_wren, reg_file_dmux_select, pc_wren}, {12'd0, 1'b1, 2'b01, 1'b1});

        // li 0xF5 with one fetch wait; start and mid-instruction halt_req are ignored.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("li_fetchwait_state", {13'd0, state}, 16'd1);
        check("li_fetchwait_irw", {15'd0, ir_wren}, 16'd0);
        cyc(1'b1, 8'hF5, 1'b0, 1'b0, 1'b0);
        check("li_fetch_state", {13'd0, state}, 16'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("li_decode_state", {13'd0, state}, 16'd2);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("li_exec_state", {13'd0, state}, 16'd3);
        check("li_exec_alu", {11'd0, alu_control, alu_mux_select}, {11'd0, 4'b0000, 1'b0});
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("li_wb_state", {13'd0, state}, 16'd5);
        check("li_wb_dmux", {14'd0, reg_file_dmux_select}, 16'b11);

        // srl 0x72: shift with immediate operand.
        cyc(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("srl_exec_alu", {11'd0, alu_control, alu_mux_select}, {11'd0, 4'b0110, 1'b1});
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("srl_wb_state", {13'd0, state}, 16'd5);

        // beq taken / not taken, bne with zero: 3 cycles each, no register write.
        for (int k = 0; k < 3; k++) begin
            logic [7:0] opc;
            logic       az;
            logic [1:0] exp_pc;
            opc    = (k == 2) ? 8'hD0 : 8'hC0;
            az     = (k != 1);
            exp_pc = (k == 0) ? 2'b01 : 2'b00;
            cyc(1'b1, opc, 1'b0, 1'b0, 1'b0);
            check("br_fetch_state", {13'd0, state}, 16'd1);
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check("br_decode_state", {13'd0, state}, 16'd2);
            cyc(1'b0, 8'h00, az, 1'b0, 1'b0);
            check("br_exec_state", {13'd0, state}, 16'd3);
            check("br_exec_alu", {12'd0, alu_control}, 16'b0111);
            check("br_exec_pc", {12'd0, pc_wren, reg_file_wren, pc_control}, {12'd0, 1'b1, 1'b0, exp_pc});
        end

        // jal 0x90 with halt_req at its boundary: IDLE afterwards.
        cyc(1'b1, 8'h90, 1'b0, 1'b0, 1'b0);
        check("jal_fetch_state", {13'd0, state}, 16'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("jal_exec_state", {13'd0, state}, 16'd3);
        check("jal_exec_ctl", {9'd0, pc_wren, pc_control, reg_file_wren, reg_file_dmux_select, reg_file_rmux_select},
              {9'd0, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1});
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("halt_state", {13'd0, state}, 16'd0);
        check("halt_busy", {15'd0, busy}, 16'd0);
        check("halt_strobes", strobes(), 16'h0000);

        // sw 0xB0 waiting in MEM; reset pulse drops the port before any write completes.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("sw_exec_state", {13'd0, state}, 16'd3);
        check("sw_exec_alu", {11'd0, alu_control, alu_mux_select}, {11'd0, 4'b0000, 1'b1});
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check("sw_mem_state", {13'd0, state}, 16'd4);
            check("sw_mem_port", {12'd0, mem_req, inst_mem_sel, data_mem_wren, pc_wren}, 16'b1010);
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("sw_rst_state", {13'd0, state}, 16'd0);
        check("sw_rst_port", {13'd0, mem_req, data_mem_wren, pc_wren}, 16'd0);
        check("sw_rst_strobes", strobes(), 16'h0000);
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        check("post_rst_state", {13'd0, state}, 16'd0);
        check("post_rst_strobes", strobes(), 16'h0000);

        // sw zero-wait after restart: FETCH, DECODE, EXEC, MEM(ack) -> FETCH.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        check("sw_mem_ack_state", {13'd0, state}, 16'd4);
        check("sw_mem_ack_ctl", {11'd0, mem_req, data_mem_wren, pc_wren, pc_control}, {11'd0, 1'b1, 1'b1, 1'b1, 2'b00});
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("sw_next_fetch", {13'd0, state}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
